// File: rtl/cr_crc_sched_pkg.sv
// Shared types and helpers for the cr_crc frame scheduler.
// The state encoding and the valid-byte mask check live here so the top and any checker agree.
package cr_crc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        STREAM = 2'd2,
        RESULT = 2'd3
    } sched_state_t;

    localparam int unsigned MAX_VB = 64;

    // True for a non-empty mask whose ones are contiguous from bit 0 (8'h01, 8'h03, ... 8'hFF).
    function automatic logic is_thermometer(input logic [MAX_VB-1:0] mask);
        logic seen_zero;
        logic ok;
        seen_zero = 1'b0;
        ok        = mask[0];
        for (int i = 0; i < MAX_VB; i++) begin
            if (!mask[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/cr_crc_sched_if.sv
// Request/result bus between per-channel framers, the CRC scheduler and downstream append/check logic.
// The scheduler uses the slave modport; the framer side uses master.
interface cr_crc_sched_if #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned N_CRC_WIDTH  = 32,
    parameter int unsigned N_DATA_WIDTH = 64
);
    localparam int unsigned VB   = N_DATA_WIDTH / 8;
    localparam int unsigned CH_W = $clog2(N_CH);

    logic [N_CH-1:0]              req_valid;
    logic [N_CH-1:0]              req_ready;
    logic [N_CH*N_DATA_WIDTH-1:0] req_data;
    logic [N_CH*VB-1:0]           req_vbytes;
    logic [N_CH-1:0]              req_sop;
    logic [N_CH-1:0]              req_eop;
    logic                         res_valid;
    logic                         res_ready;
    logic [N_CRC_WIDTH-1:0]       res_crc;
    logic [CH_W-1:0]              res_ch;

    modport master (
        output req_valid, req_data, req_vbytes, req_sop, req_eop, res_ready,
        input  req_ready, res_valid, res_crc, res_ch
    );

    modport slave (
        input  req_valid, req_data, req_vbytes, req_sop, req_eop, res_ready,
        output req_ready, res_valid, res_crc, res_ch
    );

endinterface

// File: rtl/cr_crc.sv
// Reflected CRC engine: byte 0 first, LSB first; only a thermometer vbytes mask feeds bytes.
// Output is the inverted running remainder.
module cr_crc #(
    parameter int unsigned          N_CRC_WIDTH  = 32,
    parameter int unsigned          N_DATA_WIDTH = 64,
    parameter logic [N_CRC_WIDTH-1:0] POLYNOMIAL = 32'h82F63B78
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      init,
    input  logic [N_CRC_WIDTH-1:0]    init_value,
    input  logic                      data_valid,
    input  logic [N_DATA_WIDTH-1:0]   data_in,
    input  logic [N_DATA_WIDTH/8-1:0] vbytes,
    output logic [N_CRC_WIDTH-1:0]    crc
);
    localparam int VB = N_DATA_WIDTH / 8;

    logic [N_CRC_WIDTH-1:0] crc_q;
    logic [N_CRC_WIDTH-1:0] crc_d;
    logic                   seen_zero;
    logic                   thermo;
    int                     n_bytes;

    always_comb begin
        seen_zero = 1'b0;
        thermo    = vbytes[0];
        n_bytes   = 0;
        for (int i = 0; i < VB; i++) begin
            if (!vbytes[i]) begin
                seen_zero = 1'b1;
            end else begin
                if (seen_zero) thermo = 1'b0;
                n_bytes = n_bytes + 1;
            end
        end
        // A malformed mask feeds nothing rather than a guessed byte count.
        if (!thermo) n_bytes = 0;

        crc_d = crc_q;
        for (int b = 0; b < VB; b++) begin
            if (b < n_bytes) begin
                for (int k = 0; k < 8; k++) begin
                    if (crc_d[0] ^ data_in[8*b+k]) begin
                        crc_d = (crc_d >> 1) ^ POLYNOMIAL;
                    end else begin
                        crc_d = crc_d >> 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (enable) begin
            if (init) begin
                crc_q <= init_value;
            end else if (data_valid) begin
                crc_q <= crc_d;
            end
        end
    end

    assign crc = ~crc_q;

endmodule

// File: rtl/cr_crc_sched_rr_arb.sv
// Round-robin picker: first requester at or after ptr_i, wrapping; purely combinational.
module cr_crc_sched_rr_arb #(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0]         req_i,
    input  logic [$clog2(N_CH)-1:0] ptr_i,
    output logic [N_CH-1:0]         gnt_oh_o,
    output logic [$clog2(N_CH)-1:0] gnt_idx_o,
    output logic                    any_o
);
    localparam int unsigned CH_W = $clog2(N_CH);

    int unsigned cand;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = 0;
        for (int i = 0; i < N_CH; i++) begin
            cand = (32'(ptr_i) + 32'(i)) % N_CH;
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                gnt_oh_o[cand] = 1'b1;
                gnt_idx_o      = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cr_crc_sched.sv
// Frame scheduler sharing one cr_crc engine across N_CH streams; states IDLE pick | INIT seed | STREAM beats | RESULT hold.
// Define CR_CRC_SCHED_CHK_EN to build the sticky protocol-error checker behind err.
module cr_crc_sched
    import cr_crc_sched_pkg::*;
#(
    parameter int unsigned            N_CH         = 4,
    parameter int unsigned            N_CRC_WIDTH  = 32,
    parameter int unsigned            N_DATA_WIDTH = 64,
    parameter logic [N_CRC_WIDTH-1:0] POLYNOMIAL   = 32'h82F63B78,
    parameter logic [N_CRC_WIDTH-1:0] INIT_VALUE   = 32'hFFFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    cr_crc_sched_if.slave        bus,
    output logic                 busy,
    output logic                 err
);
    localparam int unsigned VB   = N_DATA_WIDTH / 8;
    localparam int unsigned CH_W = $clog2(N_CH);

    sched_state_t       state_q;
    logic [CH_W-1:0]    rr_ptr_q;
    logic [CH_W-1:0]    grant_q;
    logic [N_CH-1:0]    grant_oh_q;
    logic [N_CH-1:0]    ready_q;
    logic               res_valid_q;
    logic               busy_q;

    logic [N_CH-1:0]    arb_req;
    logic [N_CH-1:0]    arb_oh;
    logic [CH_W-1:0]    arb_idx;
    logic               arb_any;

    logic                    g_valid;
    logic                    g_eop;
    logic                    accept;
    logic [N_DATA_WIDTH-1:0] g_data;
    logic [VB-1:0]           g_vbytes;
    logic [VB-1:0]           eng_vbytes;
    logic [N_CRC_WIDTH-1:0]  eng_crc;

    // Only frame starts compete; a mid-frame beat in IDLE just stalls.
    assign arb_req = bus.req_valid & bus.req_sop;

    cr_crc_sched_rr_arb #(.N_CH(N_CH)) u_arb (
        .req_i     (arb_req),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    assign g_valid    = bus.req_valid[grant_q];
    assign g_eop      = bus.req_eop[grant_q];
    assign g_data     = bus.req_data[int'(grant_q)*N_DATA_WIDTH +: N_DATA_WIDTH];
    assign g_vbytes   = bus.req_vbytes[int'(grant_q)*VB +: VB];
    assign accept     = g_valid & ready_q[grant_q];
    assign eng_vbytes = g_eop ? g_vbytes : '1;

    cr_crc #(
        .N_CRC_WIDTH  (N_CRC_WIDTH),
        .N_DATA_WIDTH (N_DATA_WIDTH),
        .POLYNOMIAL   (POLYNOMIAL)
    ) u_crc (
        .clk        (clk),
        .rst_n      (~rst),
        .enable     (1'b1),
        .init       (state_q == INIT),
        .init_value (INIT_VALUE),
        .data_valid (accept),
        .data_in    (g_data),
        .vbytes     (eng_vbytes),
        .crc        (eng_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            grant_oh_q  <= '0;
            ready_q     <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        grant_q    <= arb_idx;
                        grant_oh_q <= arb_oh;
                        busy_q     <= 1'b1;
                        state_q    <= INIT;
                    end
                end
                INIT: begin
                    ready_q <= grant_oh_q;
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (accept && g_eop) begin
                        ready_q     <= '0;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= (32'(grant_q) == N_CH - 1) ? '0 : grant_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_crc   = eng_crc;
    assign bus.res_ch    = grant_q;
    assign busy          = busy_q;

`ifdef CR_CRC_SCHED_CHK_EN
    logic first_q;
    logic err_q;
    logic g_sop;
    logic viol;

    assign g_sop = bus.req_sop[grant_q];

    always_comb begin
        viol = 1'b0;
        if (accept && g_eop && !is_thermometer(MAX_VB'(g_vbytes))) viol = 1'b1;
        if (accept && g_sop && !first_q) viol = 1'b1;
        if (state_q == IDLE && |(bus.req_valid & ~bus.req_sop)) viol = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (viol) err_q <= 1'b1;
            if (state_q == INIT) begin
                first_q <= 1'b1;
            end else if (accept) begin
                first_q <= 1'b0;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cr_crc_sched.sv
// Directed bench for cr_crc_sched: arbitration order, latency, stalls, mid-frame reset and bad masks.
module tb_cr_crc_sched;
    localparam int N_CH = 4;
    localparam int DW   = 64;
    localparam int CW   = 32;

    typedef struct packed {
        logic        gap;
        logic        sop;
        logic        eop;
        logic [7:0]  vb;
        logic [63:0] data;
    } beat_t;

    logic clk;
    logic rst;
    logic busy;
    logic err;
    int   checks;
    int   errors;

    beat_t       chq [N_CH][$];
    logic [31:0] got_crc[$];
    int          got_ch[$];
    int          stall_seen;
    int          ready_in_stall;
    int          multi_ready;

    cr_crc_sched_if #(.N_CH(N_CH), .N_CRC_WIDTH(CW), .N_DATA_WIDTH(DW)) bus ();

    cr_crc_sched #(
        .N_CH(N_CH), .N_CRC_WIDTH(CW), .N_DATA_WIDTH(DW),
        .POLYNOMIAL(32'h82F63B78), .INIT_VALUE(32'hFFFFFFFF)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_crc(input beat_t f[$]);
        logic [31:0] c;
        int n;
        c = 32'hFFFFFFFF;
        foreach (f[i]) begin
            if (f[i].gap) continue;
            n = 8;
            if (f[i].eop) begin
                n = $countones(f[i].vb);
                if (f[i].vb != 8'((16'd1 << n) - 16'd1)) n = 0;
            end
            for (int b = 0; b < n; b++) begin
                c = c ^ {24'h0, f[i].data[8*b +: 8]};
                for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'h82F63B78) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid  = '0;
        bus.req_sop    = '0;
        bus.req_eop    = '0;
        bus.req_data   = '0;
        bus.req_vbytes = '0;
        bus.res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push(input int ch, input logic [63:0] d, input logic [7:0] vb,
                        input logic sop, input logic eop);
        beat_t b;
        b.gap = 1'b0; b.sop = sop; b.eop = eop; b.vb = vb; b.data = d;
        chq[ch].push_back(b);
    endtask

    task automatic push_gap(input int ch);
        beat_t b;
        b = '0;
        b.gap = 1'b1;
        chq[ch].push_back(b);
    endtask

    // Presents queued beats, holds each result for `stall` cycles before accepting it.
    task automatic run_frames(input int stall, input int budget);
        int cyc;
        int left;
        logic [N_CH-1:0] acc;
        logic fire;
        cyc = 0; left = stall;
        stall_seen = 0; ready_in_stall = 0; multi_ready = 0;
        got_crc.delete(); got_ch.delete();
        while ((chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size() > 0
                || bus.res_valid || busy) && cyc < budget) begin
            for (int c = 0; c < N_CH; c++) begin
                if (chq[c].size() > 0 && !chq[c][0].gap) begin
                    bus.req_valid[c] = 1'b1;
                    bus.req_sop[c]   = chq[c][0].sop;
                    bus.req_eop[c]   = chq[c][0].eop;
                    bus.req_data[c*DW +: DW]  = chq[c][0].data;
                    bus.req_vbytes[c*8 +: 8]  = chq[c][0].vb;
                end else begin
                    bus.req_valid[c] = 1'b0;
                    bus.req_sop[c]   = 1'b0;
                    bus.req_eop[c]   = 1'b0;
                end
            end
            fire = 1'b0;
            if (bus.res_valid) begin
                if (left > 0) begin
                    left--;
                    stall_seen++;
                    if (bus.req_ready != '0) ready_in_stall++;
                    bus.res_ready = 1'b0;
                end else begin
                    bus.res_ready = 1'b1;
                    fire = 1'b1;
                    left = stall;
                end
            end else begin
                bus.res_ready = 1'b0;
            end
            if ($countones(bus.req_ready) > 1) multi_ready++;
            acc = bus.req_valid & bus.req_ready;
            if (fire) begin
                got_crc.push_back(bus.res_crc);
                got_ch.push_back(int'(bus.res_ch));
            end
            step();
            for (int c = 0; c < N_CH; c++) begin
                if (chq[c].size() > 0 && (acc[c] || chq[c][0].gap)) void'(chq[c].pop_front());
            end
            cyc++;
        end
        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL run_frames_timeout: ran %0d cycles, limit %0d", cyc, budget);
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        push(0, 64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
        push(0, 64'h0000000000000039, 8'h01, 1'b0, 1'b1);
        run_frames(0, 200);
        checks++; if (got_crc.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", got_crc.size()); end
        checks++; if (got_crc[0] !== 32'hE3069283) begin errors++; $display("FAIL basic_crc: got %h want e3069283", got_crc[0]); end
        checks++; if (got_ch[0] !== 0) begin errors++; $display("FAIL basic_ch: got %0d want 0", got_ch[0]); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_crc[N_CH];
        beat_t f[$];
        do_reset();
        for (int c = 0; c < N_CH; c++) begin
            logic [7:0] vb;
            vb = (c == 0) ? 8'hFF : (c == 1) ? 8'h0F : (c == 2) ? 8'h01 : 8'h7F;
            push(c, 64'h0123456789ABCDEF ^ {56'h0, 8'(c * 17)}, vb, 1'b1, 1'b1);
            f = chq[c];
            exp_crc[c] = model_crc(f);
        end
        run_frames(0, 300);
        checks++; if (got_crc.size() !== N_CH) begin errors++; $display("FAIL rr_count: got %0d want %0d", got_crc.size(), N_CH); end
        for (int i = 0; i < N_CH; i++) begin
            checks++; if (got_ch[i] !== i) begin errors++; $display("FAIL rr_order[%0d]: got ch %0d want %0d", i, got_ch[i], i); end
            checks++; if (got_crc[i] !== exp_crc[i]) begin errors++; $display("FAIL rr_crc[%0d]: got %h want %h", i, got_crc[i], exp_crc[i]); end
        end
        checks++; if (multi_ready !== 0) begin errors++; $display("FAIL rr_onehot_ready: got %0d multi-bit cycles want 0", multi_ready); end
        push(3, 64'h1111111111111111, 8'hFF, 1'b1, 1'b1);
        push(0, 64'h2222222222222222, 8'hFF, 1'b1, 1'b1);
        run_frames(0, 200);
        checks++; if (got_ch[0] !== 0) begin errors++; $display("FAIL rr_wrap_first: got ch %0d want 0", got_ch[0]); end
        checks++; if (got_ch[1] !== 3) begin errors++; $display("FAIL rr_wrap_second: got ch %0d want 3", got_ch[1]); end
    endtask

    task automatic test_gaps_stall();
        logic [31:0] crc_gapless;
        logic [31:0] exp_crc;
        beat_t f[$];
        do_reset();
        push(2, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, 1'b0);
        push(2, 64'h0102030405060708, 8'hFF, 1'b0, 1'b0);
        push(2, 64'hA5A5A5A5A5A5A5A5, 8'h3F, 1'b0, 1'b1);
        f = chq[2];
        exp_crc = model_crc(f);
        run_frames(0, 200);
        crc_gapless = got_crc[0];
        checks++; if (crc_gapless !== exp_crc) begin errors++; $display("FAIL gapless_crc: got %h want %h", crc_gapless, exp_crc); end

        do_reset();
        push(0, 64'h5555555555555555, 8'hFF, 1'b1, 1'b1);
        push(2, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, 1'b0);
        push_gap(2);
        push_gap(2);
        push(2, 64'h0102030405060708, 8'hFF, 1'b0, 1'b0);
        push_gap(2);
        push(2, 64'hA5A5A5A5A5A5A5A5, 8'h3F, 1'b0, 1'b1);
        run_frames(5, 400);
        checks++; if (got_ch[0] !== 0 || got_ch[1] !== 2) begin errors++; $display("FAIL stall_order: got %0d,%0d want 0,2", got_ch[0], got_ch[1]); end
        checks++; if (got_crc[1] !== exp_crc) begin errors++; $display("FAIL gap_crc: got %h want %h", got_crc[1], exp_crc); end
        checks++; if (stall_seen !== 10) begin errors++; $display("FAIL stall_cycles: got %0d want 10", stall_seen); end
        checks++; if (ready_in_stall !== 0) begin errors++; $display("FAIL stall_ready: got %0d ready cycles want 0", ready_in_stall); end
        checks++; if (multi_ready !== 0) begin errors++; $display("FAIL stall_onehot_ready: got %0d want 0", multi_ready); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] exp_crc;
        beat_t f[$];
        do_reset();
        bus.req_valid[1] = 1'b1; bus.req_sop[1] = 1'b1;
        bus.req_data[1*DW +: DW] = 64'h0F0E0D0C0B0A0908; bus.req_vbytes[8 +: 8] = 8'hFF;
        step();
        step();
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ready: got %b want 0010", bus.req_ready); end
        step();
        bus.req_sop[1] = 1'b0;
        bus.req_data[1*DW +: DW] = 64'h7766554433221100;
        rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", bus.req_ready); end
        rst = 1'b0;
        clear_inputs();
        step();
        push(1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1, 1'b0);
        push(1, 64'h7766554433221100, 8'hFF, 1'b0, 1'b0);
        push(1, 64'h00000000FFEEDDCC, 8'h07, 1'b0, 1'b1);
        f = chq[1];
        exp_crc = model_crc(f);
        run_frames(0, 200);
        checks++; if (got_crc[0] !== exp_crc) begin errors++; $display("FAIL replay_crc: got %h want %h", got_crc[0], exp_crc); end
        checks++; if (got_ch[0] !== 1) begin errors++; $display("FAIL replay_ch: got %0d want 1", got_ch[0]); end
    endtask

    task automatic test_bad_vbytes();
        logic [31:0] exp_crc;
        beat_t f[$];
        do_reset();
        push(0, 64'h3837363534333231, 8'h05, 1'b1, 1'b1);
        run_frames(0, 200);
        checks++; if (got_crc[0] !== 32'h00000000) begin errors++; $display("FAIL bad_vb_single: got %h want 00000000", got_crc[0]); end
        push(0, 64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
        push(0, 64'h0000000000000039, 8'h05, 1'b0, 1'b1);
        f.delete();
        push(3, 64'h3837363534333231, 8'hFF, 1'b1, 1'b1);
        f = chq[3];
        chq[3].delete();
        exp_crc = model_crc(f);
        run_frames(0, 200);
        checks++; if (got_crc[0] !== exp_crc) begin errors++; $display("FAIL bad_vb_tail: got %h want %h", got_crc[0], exp_crc); end
        step();
        step();
`ifdef CR_CRC_SCHED_CHK_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_vb_err: got %b want 1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_vb_err_clear: got %b want 0", err); end
`else
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_vb_err: got %b want 0", err); end
`endif
    endtask

    task automatic test_nonsop_idle();
        logic [31:0] exp_crc;
        beat_t f[$];
        do_reset();
        push(3, 64'hFEDCBA9876543210, 8'hFF, 1'b1, 1'b1);
        f = chq[3];
        chq[3].delete();
        exp_crc = model_crc(f);
        bus.req_valid = 4'b1010; bus.req_sop = 4'b1000; bus.req_eop = 4'b1010;
        bus.req_data[3*DW +: DW] = 64'hFEDCBA9876543210; bus.req_vbytes[24 +: 8] = 8'hFF;
        bus.req_data[1*DW +: DW] = 64'h1234;             bus.req_vbytes[8 +: 8]  = 8'hFF;
        step();
        checks++; if (bus.req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL idle_init: got ready %b busy %b want 0000 1", bus.req_ready, busy); end
        step();
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL idle_grant: got %b want 1000", bus.req_ready); end
        step();
        bus.req_valid[3] = 1'b0;
        checks++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 2'd3) begin errors++; $display("FAIL idle_result: got valid %b ch %0d want 1 3", bus.res_valid, bus.res_ch); end
        checks++; if (bus.res_crc !== exp_crc) begin errors++; $display("FAIL idle_crc: got %h want %h", bus.res_crc, exp_crc); end
`ifdef CR_CRC_SCHED_CHK_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL idle_err: got %b want 1", err); end
`else
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_err: got %b want 0", err); end
`endif
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ch1_stall: got busy %b ready %b want 0 0000", busy, bus.req_ready); end
        clear_inputs();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_round_robin();
        test_gaps_stall();
        test_reset_mid_frame();
        test_bad_vbytes();
        test_nonsop_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
